fp32_vec_addacc: RTL and testbench

- Multi-lane, handshaked successor to the single-lane registered fp32 add/select unit.
- Each of LANES lanes produces one of: zero, A, B, A+B, or a running fp32 accumulation of A over a group of beats terminated by in_last.
- Lane arithmetic uses one combinational fp32adder instance per lane.
- Sits between vector operand sources and a downstream consumer using valid/ready on both sides.

---
 rtl/fp32_vec_addacc.sv | 264 ++++++++++++++++++++++++++
 tb/tb_fp32_vec_addacc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_vec_addacc.sv
// fp32_vec_addacc: LANES-wide fp32 unit producing zero, A, B, A+B or a running sum of A over an in_last-terminated group.
// Latency: 1 cycle from accepted beat to registered result; ACC beats that do not close a group produce no output.
// Backpressure: in_ready = ~out_valid | out_ready; the result register holds while out_valid & ~out_ready.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready     input beat handshake; ain, bin, mode, in_last travel with the beat
//   out_valid / out_ready   output handshake; out, out_last, out_cnt travel with the result
//   grp_abort               one-cycle pulse when a non-ACC beat closes an open ACC group

// fp32adder: combinational IEEE-754 single add, round-to-nearest-even, subnormals supported.
// Latency: combinational.
// Backpressure: none.
module fp32adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        a_ge, eff_sub;
    logic [31:0] lg, sm;
    logic [9:0]  e_l, e_s, d, sh, e_n, e_f;
    logic [23:0] m_l, m_s;
    logic [26:0] ms_ext, ms_sh, lost_mask, ms_al, diff, m27;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic        up;
    logic [24:0] r25;
    logic [22:0] frac;

    assign a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
    assign b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
    assign a_inf = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
    assign b_inf = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);

    // Order operands by magnitude so the aligned operand is never the larger one.
    assign a_ge = (a_i[30:0] >= b_i[30:0]);
    assign lg   = a_ge ? a_i : b_i;
    assign sm   = a_ge ? b_i : a_i;

    // Subnormals use exponent 1 with no hidden bit.
    assign e_l = (lg[30:23] == 8'd0) ? 10'd1 : {2'b00, lg[30:23]};
    assign e_s = (sm[30:23] == 8'd0) ? 10'd1 : {2'b00, sm[30:23]};
    assign m_l = {lg[30:23] != 8'd0, lg[22:0]};
    assign m_s = {sm[30:23] != 8'd0, sm[22:0]};
    assign d   = e_l - e_s;

    // Three extra bits below the LSB: guard, round, sticky.
    assign ms_ext    = {m_s, 3'b000};
    assign ms_sh     = ms_ext >> d;
    assign lost_mask = ~({27{1'b1}} << d);
    assign ms_al     = {ms_sh[26:1], ms_sh[0] | (|(ms_ext & lost_mask))};

    assign eff_sub = lg[31] ^ sm[31];
    assign sum     = {1'b0, m_l, 3'b000} + {1'b0, ms_al};
    assign diff    = {m_l, 3'b000} - ms_al;

    // Leading-zero count of the difference; the highest set bit wins.
    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (diff[i]) begin
                lz = 5'(26 - i);
            end
        end
    end

    // Left-normalise, but never below exponent 1 so tiny results stay subnormal.
    assign sh = ({5'd0, lz} > (e_l - 10'd1)) ? (e_l - 10'd1) : {5'd0, lz};

    always_comb begin
        if (eff_sub) begin
            m27 = diff << sh;
            e_n = e_l - sh;
        end else if (sum[27]) begin
            m27 = {sum[27:2], sum[1] | sum[0]};
            e_n = e_l + 10'd1;
        end else begin
            m27 = sum[26:0];
            e_n = e_l;
        end
    end

    assign up  = m27[2] & (m27[1] | m27[0] | m27[3]);
    assign r25 = {1'b0, m27[26:3]} + {24'd0, up};

    // Exponent field follows the hidden bit after rounding: carry-out bumps it,
    // a missing hidden bit means the result is subnormal.
    always_comb begin
        if (r25[24]) begin
            e_f  = e_n + 10'd1;
            frac = r25[23:1];
        end else if (r25[23]) begin
            e_f  = e_n;
            frac = r25[22:0];
        end else begin
            e_f  = 10'd0;
            frac = r25[22:0];
        end
    end

    always_comb begin
        if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] ^ b_i[31]))) begin
            y_o = 32'h7FC0_0000;
        end else if (a_inf) begin
            y_o = a_i;
        end else if (b_inf) begin
            y_o = b_i;
        end else if (m27 == 27'd0) begin
            // Exact zero: negative only when both inputs are negative zeros.
            y_o = {a_i[31] & b_i[31], 31'd0};
        end else if (e_f >= 10'd255) begin
            y_o = {lg[31], 8'hFF, 23'd0};
        end else begin
            y_o = {lg[31], e_f[7:0], frac};
        end
    end
endmodule

module fp32_vec_addacc #(
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   ain,
    input  logic [32*LANES-1:0]   bin,
    input  logic [2:0]            mode,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out,
    output logic                  out_last,
    output logic [CNT_W-1:0]      out_cnt,
    output logic                  grp_abort
);
    localparam logic [2:0] M_PASS_A = 3'd1;
    localparam logic [2:0] M_PASS_B = 3'd2;
    localparam logic [2:0] M_ADD    = 3'd3;
    localparam logic [2:0] M_ACC    = 3'd4;

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    typedef struct packed {
        logic [32*LANES-1:0] dat;
        logic                last;
        logic [CNT_W-1:0]    cnt;
    } res_t;

    state_t              state_q, state_d;
    res_t                res_q, res_d;
    logic                out_vld_q, out_vld_d;
    logic                abort_q, abort_d;
    logic [32*LANES-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;

    logic                accept, acc_mode, grp_step;
    logic [32*LANES-1:0] add_a, add_b, add_y, direct_res;

    assign in_ready = ~out_vld_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign acc_mode = (mode == M_ACC);

    // The one adder per lane is shared: acc+A while extending a group, A+B otherwise.
    assign grp_step = acc_mode && (state_q == S_ACCUM);
    assign add_a    = grp_step ? acc_q : ain;
    assign add_b    = grp_step ? ain   : bin;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp32adder u_add (
            .a_i (add_a[32*i +: 32]),
            .b_i (add_b[32*i +: 32]),
            .y_o (add_y[32*i +: 32])
        );
    end

    // Reserved modes fall into the default and behave as ZERO.
    always_comb begin
        case (mode)
            M_PASS_A: direct_res = ain;
            M_PASS_B: direct_res = bin;
            M_ADD:    direct_res = add_y;
            default:  direct_res = '0;
        endcase
    end

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        out_vld_d = out_vld_q & ~out_ready;
        abort_d   = 1'b0;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        if (accept) begin
            if (acc_mode) begin
                if (state_q == S_IDLE) begin
                    if (in_last) begin
                        // Single-beat group: emit A directly, accumulators untouched.
                        res_d.dat = ain;
                        res_d.last = 1'b1;
                        res_d.cnt = CNT_W'(1);
                        out_vld_d = 1'b1;
                    end else begin
                        acc_d   = ain;
                        cnt_d   = CNT_W'(1);
                        state_d = S_ACCUM;
                    end
                end else begin
                    if (in_last) begin
                        res_d.dat = add_y;
                        res_d.last = 1'b1;
                        res_d.cnt = cnt_inc;
                        out_vld_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                    end else begin
                        acc_d = add_y;
                        cnt_d = cnt_inc;
                    end
                end
            end else begin
                res_d.dat = direct_res;
                res_d.last = in_last;
                res_d.cnt = CNT_W'(1);
                out_vld_d = 1'b1;
                // A non-ACC beat closes any open group; the stale acc is never
                // read again because the next group start loads it directly.
                if (state_q == S_ACCUM) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            res_q     <= '0;
            out_vld_q <= 1'b0;
            abort_q   <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            out_vld_q <= out_vld_d;
            abort_q   <= abort_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out       = res_q.dat;
    assign out_last  = res_q.last;
    assign out_cnt   = res_q.cnt;
    assign grp_abort = abort_q;
endmodule

// File: tb/tb_fp32_vec_addacc.sv
// Bench for fp32_vec_addacc: table of single-beat vectors plus hand-written group,
// backpressure, abort, saturation and reset sequences; results checked via a queue.
module tb_fp32_vec_addacc;
    localparam int L  = 4;
    localparam int CW = 2;
    localparam int VW = 32 * L;

    localparam logic [2:0] M_ZERO = 3'd0, M_PA = 3'd1, M_PB = 3'd2, M_ADD = 3'd3, M_ACC = 3'd4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] ain = '0;
    logic [VW-1:0] bin = '0;
    logic [2:0]    mode = 3'd0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [VW-1:0] out;
    logic          out_last;
    logic [CW-1:0] out_cnt;
    logic          grp_abort;

    always #5 clk = ~clk;

    fp32_vec_addacc #(.LANES(L), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain       (ain),
        .bin       (bin),
        .mode      (mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_last  (out_last),
        .out_cnt   (out_cnt),
        .grp_abort (grp_abort)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [VW-1:0] dat;
        logic          last;
        logic [CW-1:0] cnt;
    } want_t;

    want_t sb[$];

    typedef struct {
        logic [2:0]    md;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic          last;
        logic [VW-1:0] res;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    function automatic logic [VW-1:0] splat(input logic [31:0] v);
        return {L{v}};
    endfunction

    // Present one beat, wait (bounded) for in_ready, queue its result if it emits one.
    // Called and returns #1 after a rising edge.
    task automatic send(input logic [2:0] m, input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input logic l, input logic emit, input logic [VW-1:0] rd,
                        input logic [CW-1:0] rc);
        int w;
        want_t e;
        in_valid = 1'b1; mode = m; ain = a; bin = b; in_last = l;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready stuck at 0, required 1");
        end else if (emit) begin
            e.dat = rd; e.last = l; e.cnt = rc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Output monitor: every taken result is compared with the oldest queued expectation.
    always @(negedge clk) begin
        want_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out: got out_valid=1 with %h, required no output", out);
            end else begin
                e = sb.pop_front();
                chk("out_result", {out, out_last, out_cnt}, e);
            end
        end
    end

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        chk("async_reset_outs", {out_valid, out, out_last, out_cnt, grp_abort}, '0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [VW-1:0] x, y;
        int w;

        tbl[0] = '{M_PA, {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}, splat(32'h12345678), 1'b0,
                   {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}};
        tbl[1] = '{M_PB, splat(32'h11111111), {32'hDEADBEEF, 32'h00000001, 32'h80000000, 32'h7F800000}, 1'b1,
                   {32'hDEADBEEF, 32'h00000001, 32'h80000000, 32'h7F800000}};
        tbl[2] = '{M_ADD, splat(32'h3F800000), splat(32'h40000000), 1'b0, splat(32'h40400000)};
        tbl[3] = '{3'd6, splat(32'h3F800000), splat(32'h40000000), 1'b1, '0};
        tbl[4] = '{M_ADD, {32'h3FC00000, 32'hC0400000, 32'h3F800000, 32'h3F800000},
                   {32'h40100000, 32'h3F800000, 32'hBF800000, 32'h33800001}, 1'b0,
                   {32'h40700000, 32'hC0000000, 32'h00000000, 32'h3F800001}};
        tbl[5] = '{M_ADD, {32'h7F800000, 32'h7F7FFFFF, 32'h00000001, 32'h3F800000},
                   {32'hFF800000, 32'h7F7FFFFF, 32'h00000001, 32'h33800000}, 1'b1,
                   {32'h7FC00000, 32'h7F800000, 32'h00000002, 32'h3F800000}};
        tbl[6] = '{M_ZERO, splat(32'h40490FDB), splat(32'h40490FDB), 1'b1, '0};
        tbl[7] = '{3'd5, splat(32'h3F800000), splat(32'h3F800000), 1'b0, '0};
        tbl[8] = '{3'd7, splat(32'hC0000000), splat(32'h3F800000), 1'b0, '0};

        // Reset state
        #12;
        chk("reset_outs", {out_valid, out, out_last, out_cnt, grp_abort}, '0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // PASS_A lane0 with 1-cycle latency
        x = {32'h0, 32'h0, 32'h0, 32'h3F800000};
        send(M_PA, x, splat(32'h40000000), 1'b0, 1'b1, x, 2'd1);
        chk("pass_a_latency", {out_valid, out[31:0], out_cnt}, {1'b1, 32'h3F800000, 2'd1});

        // Single-beat table
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].md, tbl[i].a, tbl[i].b, tbl[i].last, 1'b1, tbl[i].res, 2'd1);
        end

        // Three-beat ACC group; bin carries noise that must be ignored
        send(M_ACC, {64'h0, 32'h3F800000, 32'h3F800000}, splat(32'h7FC00000), 1'b0, 1'b0, '0, '0);
        chk("acc_beat1_no_out", out_valid, 1'b0);
        send(M_ACC, {64'h0, 32'h3F800000, 32'h40000000}, splat(32'h7FC00000), 1'b0, 1'b0, '0, '0);
        chk("acc_beat2_no_out", out_valid, 1'b0);
        send(M_ACC, {64'h0, 32'h3F800000, 32'h40400000}, splat(32'h7FC00000), 1'b1, 1'b1,
             {64'h0, 32'h40400000, 32'h40C00000}, 2'd3);
        chk("acc_group_out", {out_valid, out_last, out_cnt, out[31:0]}, {1'b1, 1'b1, 2'd3, 32'h40C00000});

        // Backpressure with simultaneous take and load
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        x = splat(32'h41200000);
        y = splat(32'hC1200000);
        send(M_PA, x, '0, 1'b0, 1'b1, x, 2'd1);
        in_valid = 1'b1; mode = M_PB; ain = '0; bin = y; in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 1'b0);
            chk("bp_out_stable", {out_valid, out}, {1'b1, x});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        sb.push_back('{dat: y, last: 1'b1, cnt: 2'd1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_take_and_load", {out_valid, out}, {1'b1, y});

        // Abort of an open group by an ADD beat
        send(M_ACC, splat(32'h3F800000), '0, 1'b0, 1'b0, '0, '0);
        chk("abort_pre_low", grp_abort, 1'b0);
        send(M_ADD, splat(32'h3F800000), splat(32'h3F800000), 1'b0, 1'b1, splat(32'h40000000), 2'd1);
        chk("abort_pulse_high", grp_abort, 1'b1);
        @(posedge clk);
        #1;
        chk("abort_pulse_one_cycle", grp_abort, 1'b0);
        send(M_ACC, splat(32'h40000000), '0, 1'b1, 1'b1, splat(32'h40000000), 2'd1);

        // Counter saturation at 2^CW-1
        for (int k = 0; k < 4; k++) begin
            send(M_ACC, splat(32'h3F800000), '0, 1'b0, 1'b0, '0, '0);
        end
        send(M_ACC, splat(32'h3F800000), '0, 1'b1, 1'b1, splat(32'h40A00000), 2'd3);

        // Reset while a result is held
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(M_PA, splat(32'h40400000), '0, 1'b1, 1'b1, splat(32'h40400000), 2'd1);
        reset_pulse();
        out_ready = 1'b1;

        // Reset mid-group: the next ACC beat starts a fresh group
        send(M_ACC, splat(32'h40A00000), '0, 1'b0, 1'b0, '0, '0);
        reset_pulse();
        send(M_ACC, splat(32'h3F800000), '0, 1'b1, 1'b1, splat(32'h3F800000), 2'd1);

        w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
